// File: rtl/mul_pipe_unit.sv
// Pipelined radix-4 Booth / Wallace multiply(-accumulate) unit for the execute stage.
// Results are {HI,LO} modulo 2^(2*WIDTH); depth only changes latency, never the value.
module mul_pipe_unit #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic                 in_sign,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2*WIDTH-1:0]   in_acc,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);
    localparam int RW = 2 * WIDTH;
    localparam int ND = WIDTH / 2 + 1;
    localparam int NR = ND + 1;

    function automatic int csa_levels(input int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = (n / 3) * 2 + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int NLVL = csa_levels(NR);

    logic                   stall;
    logic                   msub;
    logic [RW-1:0]          a_ext;
    logic [WIDTH+2:0]       b_win;
    logic [2:0]             dig;
    logic [RW-1:0]          mag;
    logic                   neg;
    logic [RW-1:0]          pp;
    logic [NR-1:0][RW-1:0]  rows_d, rows_q;
    logic [NR-1:0][RW-1:0]  csa_cur, csa_nxt;
    int                     csa_n;
    logic [RW-1:0]          ws, wc;
    logic                   v1_q;
    logic [TAG_W-1:0]       tag1_q;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !flush;
    assign msub     = (in_op == 2'd2);

    // Booth rows; MSUB folds the subtraction into the digit sign, the accumulator is the last row.
    always_comb begin
        a_ext  = {{WIDTH{in_sign & in_a[WIDTH-1]}}, in_a};
        b_win  = {{2{in_sign & in_b[WIDTH-1]}}, in_b, 1'b0};
        rows_d = '0;
        dig    = '0;
        mag    = '0;
        neg    = 1'b0;
        pp     = '0;
        for (int i = 0; i < ND; i++) begin
            dig = b_win[2*i +: 3];
            mag = '0;
            neg = 1'b0;
            case (dig)
                3'b001, 3'b010: mag = a_ext;
                3'b011:         mag = a_ext << 1;
                3'b100: begin
                    mag = a_ext << 1;
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = a_ext;
                    neg = 1'b1;
                end
                default: mag = '0;
            endcase
            pp        = (neg ^ msub) ? (~mag + RW'(1)) : mag;
            rows_d[i] = pp << (2 * i);
        end
        rows_d[ND] = (in_op == 2'd1 || in_op == 2'd2) ? in_acc : '0;
    end

    // Wallace reduction: each level turns every group of three rows into sum + shifted carry.
    always_comb begin
        csa_cur = rows_q;
        csa_nxt = '0;
        csa_n   = NR;
        for (int l = 0; l < NLVL; l++) begin
            csa_nxt = '0;
            for (int g = 0; g < NR / 3; g++) begin
                if (g < csa_n / 3) begin
                    csa_nxt[2*g]   = csa_cur[3*g] ^ csa_cur[3*g+1] ^ csa_cur[3*g+2];
                    csa_nxt[2*g+1] = ((csa_cur[3*g] & csa_cur[3*g+1]) |
                                      (csa_cur[3*g] & csa_cur[3*g+2]) |
                                      (csa_cur[3*g+1] & csa_cur[3*g+2])) << 1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < csa_n % 3) begin
                    csa_nxt[2*(csa_n/3)+r] = csa_cur[3*(csa_n/3)+r];
                end
            end
            csa_cur = csa_nxt;
            csa_n   = (csa_n / 3) * 2 + csa_n % 3;
        end
        ws = csa_cur[0];
        wc = csa_cur[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            rows_q <= '0;
            tag1_q <= '0;
        end else if (flush) begin
            v1_q <= 1'b0;
        end else if (!stall) begin
            v1_q <= in_valid;
            if (in_valid) begin
                rows_q <= rows_d;
                tag1_q <= in_tag;
            end
        end
    end

    generate
        if (PIPE_STAGES == 1) begin : g_p1
            assign out_valid  = v1_q;
            assign out_tag    = tag1_q;
            assign out_result = ws + wc;
            assign busy       = v1_q;
        end else begin : g_p23
            logic             v2_q;
            logic [RW-1:0]    s_q, c_q;
            logic [TAG_W-1:0] tag2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2_q   <= 1'b0;
                    s_q    <= '0;
                    c_q    <= '0;
                    tag2_q <= '0;
                end else if (flush) begin
                    v2_q <= 1'b0;
                end else if (!stall) begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        s_q    <= ws;
                        c_q    <= wc;
                        tag2_q <= tag1_q;
                    end
                end
            end

            if (PIPE_STAGES == 2) begin : g_p2
                assign out_valid  = v2_q;
                assign out_tag    = tag2_q;
                assign out_result = s_q + c_q;
                assign busy       = v1_q | v2_q;
            end else begin : g_p3
                logic             v3_q;
                logic [RW-1:0]    r_q;
                logic [TAG_W-1:0] tag3_q;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        v3_q   <= 1'b0;
                        r_q    <= '0;
                        tag3_q <= '0;
                    end else if (flush) begin
                        v3_q <= 1'b0;
                    end else if (!stall) begin
                        v3_q <= v2_q;
                        if (v2_q) begin
                            r_q    <= s_q + c_q;
                            tag3_q <= tag2_q;
                        end
                    end
                end

                assign out_valid  = v3_q;
                assign out_tag    = tag3_q;
                assign out_result = r_q;
                assign busy       = v1_q | v2_q | v3_q;
            end
        end
    endgenerate
endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit: depths 1/2/3 at 32 bits share stimulus, plus a 16-bit instance.
module tb_mul_pipe_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, out_ready, in_valid, in_sign;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [63:0] in_acc;
    logic [3:0]  in_tag;

    logic        rdy1, ov1, bsy1, rdy2, ov2, bsy2, rdy3, ov3, bsy3;
    logic [63:0] res1, res2, res3;
    logic [3:0]  tag1, tag2, tag3;

    logic        v16, s16, rdy16, ov16, bsy16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic [31:0] acc16, res16;
    logic [3:0]  t16, tag16;

    int total = 0;
    int bad   = 0;

    mul_pipe_unit #(.WIDTH(32), .PIPE_STAGES(1), .TAG_W(4)) u_p1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
        .in_sign(in_sign), .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_tag(in_tag),
        .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_result(res1),
        .out_tag(tag1), .busy(bsy1));

    mul_pipe_unit #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_op(in_op),
        .in_sign(in_sign), .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_tag(in_tag),
        .flush(flush), .out_valid(ov2), .out_ready(out_ready), .out_result(res2),
        .out_tag(tag2), .busy(bsy2));

    mul_pipe_unit #(.WIDTH(32), .PIPE_STAGES(3), .TAG_W(4)) u_p3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3), .in_op(in_op),
        .in_sign(in_sign), .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_tag(in_tag),
        .flush(flush), .out_valid(ov3), .out_ready(out_ready), .out_result(res3),
        .out_tag(tag3), .busy(bsy3));

    mul_pipe_unit #(.WIDTH(16), .PIPE_STAGES(2), .TAG_W(4)) u_w16 (
        .clk(clk), .reset(reset), .in_valid(v16), .in_ready(rdy16), .in_op(op16),
        .in_sign(s16), .in_a(a16), .in_b(b16), .in_acc(acc16), .in_tag(t16),
        .flush(flush), .out_valid(ov16), .out_ready(out_ready), .out_result(res16),
        .out_tag(tag16), .busy(bsy16));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic v, input logic [1:0] op, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] acc, input logic [3:0] t);
        in_valid = v;
        in_op    = op;
        in_sign  = sg;
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        in_tag   = t;
    endtask

    // One op into all three 32-bit depths; latency and value checked per instance.
    task automatic run_lat(input string nm, input logic [1:0] op, input logic sg,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] acc, input logic [63:0] exp);
        int l1, l2, l3;
        logic [63:0] r1, r2, r3;
        logic [3:0]  t2;
        l1 = 0; l2 = 0; l3 = 0;
        r1 = '0; r2 = '0; r3 = '0; t2 = '0;
        @(negedge clk);
        out_ready = 1'b1;
        put(1'b1, op, sg, a, b, acc, 4'h9);
        #1;
        chk({nm, "_rdy"}, 64'(rdy2), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (ov1 && l1 == 0) begin l1 = k; r1 = res1; end
            if (ov2 && l2 == 0) begin l2 = k; r2 = res2; t2 = tag2; end
            if (ov3 && l3 == 0) begin l3 = k; r3 = res3; end
        end
        chk({nm, "_lat_p1"}, 64'(l1), 64'd1);
        chk({nm, "_lat_p2"}, 64'(l2), 64'd2);
        chk({nm, "_lat_p3"}, 64'(l3), 64'd3);
        chk({nm, "_res_p1"}, r1, exp);
        chk({nm, "_res_p2"}, r2, exp);
        chk({nm, "_res_p3"}, r3, exp);
        chk({nm, "_tag_p2"}, 64'(t2), 64'h9);
    endtask

    task automatic run16(input string nm, input logic [1:0] op, input logic sg,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] acc, input logic [31:0] exp);
        int lat;
        logic [31:0] r;
        lat = 0;
        r   = '0;
        @(negedge clk);
        out_ready = 1'b1;
        v16 = 1'b1; op16 = op; s16 = sg; a16 = a; b16 = b; acc16 = acc; t16 = 4'h3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            v16 = 1'b0;
            if (ov16 && lat == 0) begin lat = k; r = res16; end
        end
        chk({nm, "_lat"}, 64'(lat), 64'd2);
        chk({nm, "_res"}, 64'(r), 64'(exp));
    endtask

    logic [3:0]  q_tag[$];
    logic [63:0] q_res[$];
    int nxt, got_n;

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        put(1'b0, 2'd0, 1'b0, '0, '0, '0, '0);
        v16 = 1'b0; op16 = '0; s16 = 1'b0; a16 = '0; b16 = '0; acc16 = '0; t16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ov", 64'(ov2), 64'd0);
        chk("rst_busy", 64'(bsy2), 64'd0);
        chk("rst_rdy", 64'(rdy2), 64'd1);
        chk("rst_res", res2, 64'd0);
        chk("rst_tag", 64'(tag2), 64'd0);
        reset = 1'b0;

        run_lat("t1_smul", 2'd0, 1'b1, 32'hFFFFFFFF, 32'h2, 64'h0, 64'hFFFFFFFF_FFFFFFFE);
        run_lat("t1_umul", 2'd0, 1'b0, 32'hFFFFFFFF, 32'h2, 64'h0, 64'h00000001_FFFFFFFE);
        run_lat("t2_sneg", 2'd0, 1'b1, 32'h80000000, 32'h80000000, 64'h0, 64'h40000000_00000000);
        run_lat("t2_uone", 2'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFE_00000001);
        run_lat("t3_msub", 2'd2, 1'b1, 32'd3, 32'd4, 64'h5, 64'hFFFFFFFF_FFFFFFF9);
        run_lat("t3_madd", 2'd1, 1'b0, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h0);
        run_lat("t3_rsvd", 2'd3, 1'b0, 32'd7, 32'd6, 64'd100, 64'd42);

        // back-to-back stream with a three-cycle output stall
        nxt = 1;
        got_n = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (nxt <= 5) put(1'b1, 2'd0, 1'b0, 32'(10 * nxt), 32'(nxt), 64'hDEAD, 4'(nxt));
            else in_valid = 1'b0;
            #1;
            chk("t4_rdy", 64'(rdy2), 64'(out_ready));
            if (!out_ready) chk("t4_ov_stall", 64'(ov2), 64'd1);
            if (in_valid && rdy2) begin
                q_tag.push_back(4'(nxt));
                q_res.push_back(64'(10 * nxt * nxt));
                nxt++;
            end
            if (ov2) begin
                if (q_tag.size() == 0) begin
                    chk("t4_spurious", 64'(ov2), 64'd0);
                end else begin
                    chk("t4_tag", 64'(tag2), 64'(q_tag[0]));
                    chk("t4_res", res2, q_res[0]);
                    if (out_ready) begin
                        void'(q_tag.pop_front());
                        void'(q_res.pop_front());
                        got_n++;
                    end
                end
            end
        end
        chk("t4_count", 64'(got_n), 64'd5);
        out_ready = 1'b1;
        in_valid  = 1'b0;

        // flush with two in flight and a third offered
        @(negedge clk);
        put(1'b1, 2'd0, 1'b1, 32'd7, 32'd3, '0, 4'hA);
        @(negedge clk);
        put(1'b1, 2'd0, 1'b1, 32'd5, 32'd5, '0, 4'hB);
        @(negedge clk);
        put(1'b1, 2'd0, 1'b1, 32'd2, 32'd2, '0, 4'hC);
        flush = 1'b1;
        #1;
        chk("t5_rdy_flush", 64'(rdy2), 64'd0);
        chk("t5_busy_pre", 64'(bsy2), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_busy_post", 64'(bsy2), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t5_no_ov", 64'(ov2), 64'd0);
            @(negedge clk);
        end
        run_lat("t5_next", 2'd0, 1'b1, 32'hFFFFFFFD, 32'd4, 64'h0, 64'hFFFFFFFF_FFFFFFF4);

        // reset with two in flight
        @(negedge clk);
        put(1'b1, 2'd0, 1'b0, 32'd7, 32'd3, '0, 4'h1);
        @(negedge clk);
        put(1'b1, 2'd0, 1'b0, 32'd9, 32'd9, '0, 4'h2);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_ov", 64'(ov2), 64'd0);
        chk("t6_res", res2, 64'd0);
        chk("t6_busy", 64'(bsy2), 64'd0);
        chk("t6_rdy", 64'(rdy2), 64'd1);
        chk("t6_busy_p3", 64'(bsy3), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_ov_after", 64'(ov2), 64'd0);

        run16("t6_w16_s", 2'd0, 1'b1, 16'hFFFF, 16'h0002, 32'h0, 32'hFFFFFFFE);
        run16("t6_w16_u", 2'd0, 1'b0, 16'hFFFF, 16'h0002, 32'h0, 32'h0001FFFE);
        run16("t6_w16_n", 2'd0, 1'b1, 16'h8000, 16'h8000, 32'h0, 32'h40000000);
        run16("t6_w16_m", 2'd2, 1'b1, 16'd3, 16'd4, 32'd5, 32'hFFFFFFF9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
